// File: rtl/lpddr3_rx_checker.sv
// LPDDR3 receive-side pattern checker: acquires the transmitter's free-running byte counter
// from captured DQ/DQS rise/fall words, locks to it, then counts and records bit errors.
module lpddr3_rx_checker #(
  parameter int DQ_WIDTH     = 16,
  parameter int LOCK_COUNT   = 8,
  parameter int UNLOCK_COUNT = 4,
  parameter int ERR_CNT_W    = 16,
  localparam int NL          = DQ_WIDTH / 8
) (
  input  logic                 SYS_CLK,
  input  logic                 RST,
  input  logic                 enable,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [DQ_WIDTH-1:0]  dq_rise,
  input  logic [DQ_WIDTH-1:0]  dq_fall,
  input  logic [NL-1:0]        dqs_rise,
  input  logic [NL-1:0]        dqs_fall,
  output logic [1:0]           state,
  output logic                 locked,
  output logic [31:0]          word_cnt,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [DQ_WIDTH-1:0]  err_bits,
  output logic [NL-1:0]        dqs_err,
  output logic                 err_pulse
);

  localparam int RW = $clog2(LOCK_COUNT + 1);
  localparam int BW = (UNLOCK_COUNT < 1) ? 1 : $clog2(UNLOCK_COUNT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t             st;
  logic [RW-1:0]      run;
  logic [RW-1:0]      run_inc;
  logic [BW-1:0]      bad_run;
  logic [BW-1:0]      bad_run_inc;
  logic [7:0]         last;
  logic [7:0]         exp_cnt;
  logic [7:0]         r;
  logic [DQ_WIDTH-1:0] rep_r;
  logic [DQ_WIDTH-1:0] rep_e;
  logic [DQ_WIDTH-1:0] mismatch;
  logic [NL-1:0]      dqs_r_ref;
  logic [NL-1:0]      dqs_e_ref;
  logic [NL-1:0]      dqs_mis;
  logic               consistent;
  logic               bad;

  assign state = st;

  always_comb begin
    r         = dq_rise[7:0];
    rep_r     = {NL{r}};
    rep_e     = {NL{exp_cnt}};
    dqs_r_ref = '0;
    dqs_e_ref = '0;
    for (int unsigned l = 0; l < NL; l++) begin
      dqs_r_ref[l] = r[3'(l % 8)];
      dqs_e_ref[l] = exp_cnt[3'(l % 8)];
    end
    consistent = (dq_rise == rep_r) && (dq_fall == ~dq_rise) &&
                 (dqs_rise == dqs_r_ref) && (dqs_fall == ~dqs_rise);
    mismatch    = (dq_rise ^ rep_e) | (dq_fall ^ ~rep_e);
    dqs_mis     = (dqs_rise ^ dqs_e_ref) | (dqs_fall ^ ~dqs_e_ref);
    bad         = (|mismatch) || (|dqs_mis);
    run_inc     = (run == '0 || r == 8'(last + 8'd1)) ? RW'(run + 1'b1) : RW'(1);
    bad_run_inc = BW'(bad_run + 1'b1);
  end

  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      st        <= IDLE;
      locked    <= 1'b0;
      run       <= '0;
      bad_run   <= '0;
      last      <= '0;
      exp_cnt   <= '0;
      word_cnt  <= '0;
      err_cnt   <= '0;
      err_bits  <= '0;
      dqs_err   <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (!enable) begin
        st     <= IDLE;
        locked <= 1'b0;
      end else begin
        case (st)
          IDLE: begin
            st  <= SEARCH;
            run <= '0;
          end
          SEARCH: if (in_valid) begin
            last <= r;
            if (!consistent) begin
              run <= '0;
            end else if (run_inc == RW'(LOCK_COUNT)) begin
              st      <= LOCKED;
              locked  <= 1'b1;
              exp_cnt <= 8'(r + 8'd1);
              bad_run <= '0;
              run     <= '0;
            end else begin
              run <= run_inc;
            end
          end
          LOCKED: if (in_valid) begin
            exp_cnt  <= 8'(exp_cnt + 8'd1);
            word_cnt <= word_cnt + 32'd1;
            if (bad) begin
              if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
              err_bits  <= err_bits | mismatch;
              dqs_err   <= dqs_err | dqs_mis;
              err_pulse <= 1'b1;
              bad_run   <= bad_run_inc;
              if (UNLOCK_COUNT != 0 && bad_run_inc == BW'(UNLOCK_COUNT)) begin
                st     <= SEARCH;
                locked <= 1'b0;
                run    <= '0;
              end
            end else begin
              bad_run <= '0;
            end
          end
          default: begin
            st     <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
      // Clear is evaluated last so it overrides any same-cycle count update.
      if (clear) begin
        word_cnt <= '0;
        err_cnt  <= '0;
        err_bits <= '0;
        dqs_err  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lpddr3_rx_checker.sv
// Bench for lpddr3_rx_checker: vector table, hand sequences and random traffic against a
// pattern-level reference model; a second instance covers saturation with unlock disabled.
module tb_lpddr3_rx_checker;

  logic        SYS_CLK = 1'b0;
  logic        RST = 1'b1;
  logic        enable = 1'b0, clear = 1'b0, in_valid = 1'b0;
  logic [15:0] dq_rise = '0, dq_fall = '0;
  logic [1:0]  dqs_rise = '0, dqs_fall = '0;
  logic [1:0]  state;
  logic        locked, err_pulse;
  logic [31:0] word_cnt;
  logic [15:0] err_cnt, err_bits;
  logic [1:0]  dqs_err;

  logic        b_en = 1'b0, b_clr = 1'b0, b_vld = 1'b0;
  logic [15:0] b_dqr = '0, b_dqf = '0;
  logic [1:0]  b_dqsr = '0, b_dqsf = '0;
  logic [1:0]  b_state;
  logic        b_locked, b_pulse;
  logic [31:0] b_word;
  logic [3:0]  b_err;
  logic [15:0] b_bits;
  logic [1:0]  b_dqs_err;

  int errors = 0;
  int checks = 0;

  always #5 SYS_CLK = ~SYS_CLK;

  lpddr3_rx_checker dut (
    .SYS_CLK(SYS_CLK), .RST(RST), .enable(enable), .clear(clear), .in_valid(in_valid),
    .dq_rise(dq_rise), .dq_fall(dq_fall), .dqs_rise(dqs_rise), .dqs_fall(dqs_fall),
    .state(state), .locked(locked), .word_cnt(word_cnt), .err_cnt(err_cnt),
    .err_bits(err_bits), .dqs_err(dqs_err), .err_pulse(err_pulse));

  lpddr3_rx_checker #(.ERR_CNT_W(4), .UNLOCK_COUNT(0)) dut_b (
    .SYS_CLK(SYS_CLK), .RST(RST), .enable(b_en), .clear(b_clr), .in_valid(b_vld),
    .dq_rise(b_dqr), .dq_fall(b_dqf), .dqs_rise(b_dqsr), .dqs_fall(b_dqsf),
    .state(b_state), .locked(b_locked), .word_cnt(b_word), .err_cnt(b_err),
    .err_bits(b_bits), .dqs_err(b_dqs_err), .err_pulse(b_pulse));

  typedef struct packed { logic [15:0] r, f; logic [1:0] sr, sf; } pat_t;

  function automatic pat_t pat(input logic [7:0] v);
    pat_t p;
    p.r  = {2{v}};
    p.f  = ~p.r;
    p.sr = v[1:0];
    p.sf = ~v[1:0];
    return p;
  endfunction

  // Reference model: words judged by comparing against the ideal pattern of a counter value.
  int          m_state, m_run, m_bad_run;
  logic [7:0]  m_last, m_exp, m_r;
  logic [31:0] m_word;
  int          m_err;
  logic [15:0] m_bits, m_mis;
  logic [1:0]  m_dqs, m_dm;
  logic        m_pulse;
  pat_t        m_p;

  always @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      m_state = 0; m_run = 0; m_bad_run = 0; m_last = 0; m_exp = 0;
      m_word = 0; m_err = 0; m_bits = 0; m_dqs = 0; m_pulse = 0;
    end else begin
      m_pulse = 0;
      if (!enable) m_state = 0;
      else if (m_state == 0) begin m_state = 1; m_run = 0; end
      else if (in_valid && m_state == 1) begin
        m_r = dq_rise[7:0];
        m_p = pat(m_r);
        if ({dq_rise, dq_fall, dqs_rise, dqs_fall} != m_p) m_run = 0;
        else if (m_run == 0 || m_r == 8'(m_last + 1)) m_run++;
        else m_run = 1;
        m_last = m_r;
        if (m_run == 8) begin m_state = 2; m_exp = 8'(m_r + 1); m_bad_run = 0; m_run = 0; end
      end else if (in_valid && m_state == 2) begin
        m_p   = pat(m_exp);
        m_mis = (dq_rise ^ m_p.r) | (dq_fall ^ m_p.f);
        m_dm  = (dqs_rise ^ m_p.sr) | (dqs_fall ^ m_p.sf);
        m_exp = 8'(m_exp + 1);
        m_word = m_word + 1;
        if (m_mis != 0 || m_dm != 0) begin
          if (m_err < 65535) m_err++;
          m_bits |= m_mis; m_dqs |= m_dm; m_pulse = 1; m_bad_run++;
          if (m_bad_run == 4) begin m_state = 1; m_run = 0; end
        end else m_bad_run = 0;
      end
      if (clear) begin m_word = 0; m_err = 0; m_bits = 0; m_dqs = 0; end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge SYS_CLK);
    @(negedge SYS_CLK);
    chk("m_state", 64'(state), 64'(m_state));
    chk("m_locked", 64'(locked), 64'(m_state == 2));
    chk("m_word_cnt", 64'(word_cnt), 64'(m_word));
    chk("m_err_cnt", 64'(err_cnt), 64'(m_err));
    chk("m_err_bits", 64'(err_bits), 64'(m_bits));
    chk("m_dqs_err", 64'(dqs_err), 64'(m_dqs));
    chk("m_err_pulse", 64'(err_pulse), 64'(m_pulse));
  endtask

  task automatic drive(input logic en, input logic clr, input logic vld, input logic [7:0] v,
                       input logic [15:0] rmask);
    pat_t p = pat(v);
    enable = en; clear = clr; in_valid = vld;
    dq_rise = p.r ^ rmask; dq_fall = p.f; dqs_rise = p.sr; dqs_fall = p.sf;
    tick();
  endtask

  task automatic b_drive(input logic [7:0] v, input logic [1:0] sfmask);
    pat_t p = pat(v);
    b_en = 1'b1; b_vld = 1'b1;
    b_dqr = p.r; b_dqf = p.f; b_dqsr = p.sr; b_dqsf = p.sf ^ sfmask;
    tick();
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_state"}, 64'(state), 0);
    chk({tag, "_locked"}, 64'(locked), 0);
    chk({tag, "_word_cnt"}, 64'(word_cnt), 0);
    chk({tag, "_err_cnt"}, 64'(err_cnt), 0);
    chk({tag, "_err_bits"}, 64'(err_bits), 0);
    chk({tag, "_dqs_err"}, 64'(dqs_err), 0);
    chk({tag, "_err_pulse"}, 64'(err_pulse), 0);
    chk({tag, "_b_err_cnt"}, 64'(b_err), 0);
  endtask

  typedef struct { logic en, clr, vld; logic [7:0] v; logic [15:0] rmask; int st; logic lk, pl; } vec_t;
  vec_t        tbl[19];
  logic [7:0]  nxt;
  pat_t        rp;

  initial begin
    tbl[0]  = '{1, 0, 0, 8'h00, 16'h0000, 1, 0, 0};
    tbl[1]  = '{1, 0, 1, 8'hFA, 16'h0000, 1, 0, 0};
    tbl[2]  = '{1, 0, 1, 8'hFB, 16'h0000, 1, 0, 0};
    tbl[3]  = '{1, 0, 1, 8'hFC, 16'h0000, 1, 0, 0};
    tbl[4]  = '{1, 0, 0, 8'h37, 16'h00F0, 1, 0, 0};
    tbl[5]  = '{1, 0, 0, 8'h37, 16'h00F0, 1, 0, 0};
    tbl[6]  = '{1, 0, 0, 8'h37, 16'h00F0, 1, 0, 0};
    tbl[7]  = '{1, 0, 1, 8'hFD, 16'h0000, 1, 0, 0};
    tbl[8]  = '{1, 0, 1, 8'hFE, 16'h0000, 1, 0, 0};
    tbl[9]  = '{1, 0, 1, 8'hFF, 16'h0000, 1, 0, 0};
    tbl[10] = '{1, 0, 1, 8'h00, 16'h0000, 1, 0, 0};
    tbl[11] = '{1, 0, 1, 8'h01, 16'h0000, 2, 1, 0};
    tbl[12] = '{1, 0, 1, 8'h02, 16'h0000, 2, 1, 0};
    tbl[13] = '{1, 0, 0, 8'h37, 16'h1234, 2, 1, 0};
    tbl[14] = '{1, 0, 0, 8'h37, 16'h1234, 2, 1, 0};
    tbl[15] = '{1, 0, 0, 8'h37, 16'h1234, 2, 1, 0};
    tbl[16] = '{1, 0, 1, 8'h03, 16'h0000, 2, 1, 0};
    tbl[17] = '{1, 0, 1, 8'h04, 16'h0200, 2, 1, 1};
    tbl[18] = '{1, 0, 1, 8'h05, 16'h0000, 2, 1, 0};

    // Reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      enable = 1'(($urandom)); in_valid = 1'($urandom); clear = 1'($urandom);
      dq_rise = 16'($urandom); dq_fall = 16'($urandom);
      dqs_rise = 2'($urandom); dqs_fall = 2'($urandom);
      @(negedge SYS_CLK);
      zero_chk("reset");
    end
    drive(0, 0, 0, 8'h00, 16'h0);
    RST = 1'b0;
    drive(0, 0, 0, 8'h00, 16'h0);

    // Acquisition with gaps, lock after 0x01, single-bit flip on dq_rise[9]
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].en, tbl[i].clr, tbl[i].vld, tbl[i].v, tbl[i].rmask);
      chk($sformatf("tbl%0d_state", i), 64'(state), 64'(tbl[i].st));
      chk($sformatf("tbl%0d_locked", i), 64'(locked), 64'(tbl[i].lk));
      chk($sformatf("tbl%0d_pulse", i), 64'(err_pulse), 64'(tbl[i].pl));
    end
    chk("flip_err_cnt", 64'(err_cnt), 1);
    chk("flip_err_bits", 64'(err_bits), 64'h0200);
    chk("flip_word_cnt", 64'(word_cnt), 4);

    // 600 clean words across counter wraps
    drive(1, 1, 0, 8'h00, 16'h0);
    nxt = 8'h06;
    for (int i = 0; i < 600; i++) begin drive(1, 0, 1, nxt, 16'h0); nxt++; end
    chk("clean_word_cnt", 64'(word_cnt), 600);
    chk("clean_err_cnt", 64'(err_cnt), 0);
    chk("clean_locked", 64'(locked), 1);

    // Counter slip: four bad words unlock, eight clean words re-lock
    drive(1, 1, 0, 8'h00, 16'h0);
    nxt++;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 1, nxt, 16'h0); nxt++;
      chk($sformatf("slip%0d_state", i), 64'(state), (i == 3) ? 1 : 2);
    end
    chk("slip_err_cnt", 64'(err_cnt), 4);
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 1, nxt, 16'h0); nxt++;
      chk($sformatf("relock%0d_state", i), 64'(state), (i == 7) ? 2 : 1);
    end

    // Clear with a bad word, then disable while locked
    drive(1, 1, 1, nxt, 16'h0001); nxt++;
    chk("clrbad_err_cnt", 64'(err_cnt), 0);
    chk("clrbad_err_bits", 64'(err_bits), 0);
    chk("clrbad_pulse", 64'(err_pulse), 1);
    drive(1, 0, 1, nxt, 16'h0); nxt++;
    drive(1, 0, 1, nxt, 16'h0); nxt++;
    chk("clrbad_word_cnt", 64'(word_cnt), 2);
    drive(0, 0, 1, nxt, 16'h0); nxt++;
    chk("dis_state", 64'(state), 0);
    chk("dis_word_cnt", 64'(word_cnt), 2);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      enable   = ($urandom_range(0, 199) != 0);
      clear    = ($urandom_range(0, 59) == 0);
      in_valid = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 149) == 0) nxt++;
      rp = pat(nxt);
      dq_rise  = rp.r ^ (($urandom_range(0, 39) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'h0);
      dq_fall  = ($urandom_range(0, 299) == 0) ? 16'($urandom) : rp.f;
      dqs_rise = rp.sr;
      dqs_fall = rp.sf ^ (($urandom_range(0, 99) == 0) ? 2'b01 : 2'b00);
      if (in_valid) nxt++;
      tick();
    end

    // Saturating 4-bit counter with unlock disabled
    enable = 1'b1; clear = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 9; i++) b_drive(8'(i), 2'b00);
    chk("b_locked", 64'(b_locked), 1);
    for (int i = 9; i < 29; i++) b_drive(8'(i), 2'b10);
    chk("b_err_cnt", 64'(b_err), 15);
    chk("b_dqs_err", 64'(b_dqs_err), 2'b10);
    chk("b_err_bits", 64'(b_bits), 0);
    chk("b_word_cnt", 64'(b_word), 20);
    chk("b_still_locked", 64'(b_locked), 1);

    // Asynchronous reset between clock edges
    #2 RST = 1'b1;
    #1 zero_chk("async_rst");
    @(negedge SYS_CLK);
    RST = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
